// File: rtl/hack_pkg.sv
// Shared definitions for the Hack computer test harness blocks.
package hack_pkg;

  localparam int HACK_DATA_W = 16;
  localparam int HACK_ADDR_W = 15;

  // Run-controller states, in the order a case walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_LOAD,
    ST_RUN,
    ST_READ,
    ST_EMIT
  } seq_state_t;

endpackage

// File: rtl/halt_detector.sv
// Flags a CPU as halted once its PC has stayed unchanged for HALT_WINDOW
// consecutive compares. 'clear' reloads the PC-compare register with the
// current pc and restarts the window; 'enable' marks cycles that count.
module halt_detector #(
  parameter int ADDR_W      = 15,
  parameter int HALT_WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int CW = $clog2(HALT_WINDOW + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     same_q, same_d;

  // Track the previous pc and the length of the current unchanged run;
  // the run length saturates at HALT_WINDOW.
  always_comb begin
    pc_d   = pc_q;
    same_d = same_q;
    halted = 1'b0;
    if (clear) begin
      pc_d   = pc;
      same_d = '0;
    end else if (enable) begin
      pc_d = pc;
      if (pc == pc_q) begin
        if (same_q != CW'(HALT_WINDOW)) same_d = same_q + CW'(1);
      end else begin
        same_d = '0;
      end
      halted = (same_d == CW'(HALT_WINDOW));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      same_q <= '0;
    end else begin
      pc_q   <= pc_d;
      same_q <= same_d;
    end
  end

endmodule

// File: rtl/hack_test_sequencer.sv
// Run controller for a Hack Computer: holds the CPU in reset, loads argument
// words into RAM, runs the CPU for a bounded time, then streams results out.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both 1. Producers keep data stable while valid=1 and ready=0; arg_ready is
// only ever 1 in LOAD, res_valid only in EMIT.
module hack_test_sequencer
  import hack_pkg::*;
#(
  parameter int DATA_W       = HACK_DATA_W,
  parameter int ADDR_W       = HACK_ADDR_W,
  parameter int NUM_ARGS     = 2,
  parameter int ARG_BASE     = 0,
  parameter int NUM_RESULTS  = 1,
  parameter int RES_BASE     = 2,
  parameter int RESET_CYCLES = 4,
  parameter int RUN_CYCLES   = 50,
  parameter int HALT_DETECT  = 1,
  parameter int HALT_WINDOW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arg_valid,
  input  logic [DATA_W-1:0] arg_data,
  output logic              arg_ready,
  output logic              cpu_reset,
  output logic              host_sel,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [ADDR_W-1:0] pc,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              res_last,
  output logic              timeout,
  output logic              busy,
  output seq_state_t        state_dbg
);

  seq_state_t        state_q, state_d;
  logic [31:0]       cyc_q, cyc_d;       // HOLD length, then RUN budget
  logic [ADDR_W-1:0] idx_q, idx_d;       // argument index i / result index j
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;   // result word captured in EMIT
  logic              cap_q, cap_d;       // rdata_q holds the current word
  logic              hd_clear, hd_enable, halted, halt_hit;

  halt_detector #(
    .ADDR_W      (ADDR_W),
    .HALT_WINDOW (HALT_WINDOW)
  ) u_halt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (hd_clear),
    .enable (hd_enable),
    .pc     (pc),
    .halted (halted)
  );

  assign halt_hit  = (HALT_DETECT != 0) && halted;
  assign timeout   = timeout_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  // Next-state and output decode. RAM read data arrives the cycle after the
  // READ address, i.e. in the first EMIT cycle; it is passed straight through
  // then and held in rdata_q for any backpressure cycles that follow.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    cap_d     = cap_q;
    hd_clear  = 1'b0;
    hd_enable = 1'b0;
    cpu_reset = 1'b1;
    host_sel  = 1'b1;
    arg_ready = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    res_data  = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // The starting beat is only observed here; LOAD consumes it.
        if (arg_valid) begin
          state_d = ST_HOLD;
          cyc_d   = '0;
          idx_d   = '0;
        end
      end
      ST_HOLD: begin
        timeout_d = 1'b0;
        if (cyc_q == 32'(RESET_CYCLES - 1)) begin
          state_d = ST_LOAD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_LOAD: begin
        arg_ready = 1'b1;
        ram_addr  = ADDR_W'(ARG_BASE) + idx_q;
        ram_wdata = arg_data;
        if (arg_valid) begin
          ram_we = 1'b1;
          if (idx_q == ADDR_W'(NUM_ARGS - 1)) begin
            state_d  = ST_RUN;
            idx_d    = '0;
            cyc_d    = '0;
            hd_clear = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        host_sel  = 1'b0;
        hd_enable = 1'b1;
        if (halt_hit) begin
          state_d = ST_READ;
          idx_d   = '0;
        end else if (cyc_q == 32'(RUN_CYCLES - 1)) begin
          state_d   = ST_READ;
          idx_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_READ: begin
        ram_addr = ADDR_W'(RES_BASE) + idx_q;
        cap_d    = 1'b0;
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        ram_addr  = ADDR_W'(RES_BASE) + idx_q;
        res_valid = 1'b1;
        res_last  = (idx_q == ADDR_W'(NUM_RESULTS - 1));
        res_data  = cap_q ? rdata_q : ram_rdata;
        if (!cap_q) begin
          cap_d   = 1'b1;
          rdata_d = ram_rdata;
        end
        if (res_ready) begin
          if (res_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            state_d = ST_READ;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
      cap_q     <= cap_d;
    end
  end

endmodule

// File: tb/tb_hack_test_sequencer.sv
// Bench for hack_test_sequencer: two instances, each beside a small
// behavioural computer (sync-read RAM plus a toy CPU that writes its results
// a few cycles after reset release, then either parks its PC or runs on).
module tb_hack_test_sequencer;
  import hack_pkg::*;

  localparam int RESET_CYCLES = 4;
  localparam int RUN_CYCLES   = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1 (defaults) ----------------
  logic        arg_valid = 1'b0;
  logic [15:0] arg_data = '0;
  logic        arg_ready, cpu_reset, host_sel, ram_we;
  logic [14:0] ram_addr, pc;
  logic [15:0] ram_wdata, ram_rdata, res_data;
  logic        res_valid, res_last, timeout, busy;
  logic        res_ready = 1'b1;
  seq_state_t  state_dbg;

  hack_test_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .arg_valid(arg_valid), .arg_data(arg_data), .arg_ready(arg_ready),
    .cpu_reset(cpu_reset), .host_sel(host_sel),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pc(pc),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .res_last(res_last),
    .timeout(timeout), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- instance 2 (3 results at 16) ----------------
  logic        arg_valid_2 = 1'b0;
  logic [15:0] arg_data_2 = '0;
  logic        arg_ready_2, cpu_reset_2, host_sel_2, ram_we_2;
  logic [14:0] ram_addr_2, pc_2;
  logic [15:0] ram_wdata_2, ram_rdata_2, res_data_2;
  logic        res_valid_2, res_last_2, timeout_2, busy_2;
  logic        res_ready_2 = 1'b1;
  seq_state_t  state_dbg_2;

  hack_test_sequencer #(.NUM_RESULTS(3), .RES_BASE(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .arg_valid(arg_valid_2), .arg_data(arg_data_2), .arg_ready(arg_ready_2),
    .cpu_reset(cpu_reset_2), .host_sel(host_sel_2),
    .ram_we(ram_we_2), .ram_addr(ram_addr_2), .ram_wdata(ram_wdata_2), .ram_rdata(ram_rdata_2),
    .pc(pc_2),
    .res_valid(res_valid_2), .res_data(res_data_2), .res_ready(res_ready_2), .res_last(res_last_2),
    .timeout(timeout_2), .busy(busy_2), .state_dbg(state_dbg_2)
  );

  // ---------------- behavioural computers ----------------
  logic [15:0] mem1 [0:63];
  logic [15:0] mem2 [0:63];
  logic        halt_mode = 1'b1;   // 1: CPU parks its PC at 3; 0: PC runs on

  logic        m1_we, m2_we;
  logic [14:0] m1_addr, m2_addr;
  logic [15:0] m1_wdata, m2_wdata;
  logic        c1_we, c2_we;
  logic [15:0] c2_wdata;

  // CPU 1 writes RAM[2] = RAM[0] + RAM[1] at pc 1.
  assign c1_we    = !cpu_reset && (pc == 15'd1);
  assign m1_we    = host_sel ? ram_we    : c1_we;
  assign m1_addr  = host_sel ? ram_addr  : 15'd2;
  assign m1_wdata = host_sel ? ram_wdata : (mem1[0] + mem1[1]);

  // CPU 2 writes a+b, a-b, a^b to 16, 17, 18 at pc 1, 2, 3 and parks at 4.
  assign c2_we    = !cpu_reset_2 && (pc_2 >= 15'd1) && (pc_2 <= 15'd3);
  assign c2_wdata = (pc_2 == 15'd1) ? (mem2[0] + mem2[1]) :
                    (pc_2 == 15'd2) ? (mem2[0] - mem2[1]) : (mem2[0] ^ mem2[1]);
  assign m2_we    = host_sel_2 ? ram_we_2    : c2_we;
  assign m2_addr  = host_sel_2 ? ram_addr_2  : (15'd15 + pc_2);
  assign m2_wdata = host_sel_2 ? ram_wdata_2 : c2_wdata;

  always @(posedge clk) begin
    if (m1_we) mem1[m1_addr[5:0]] <= m1_wdata;
    ram_rdata <= mem1[m1_addr[5:0]];
    if (m2_we) mem2[m2_addr[5:0]] <= m2_wdata;
    ram_rdata_2 <= mem2[m2_addr[5:0]];
    if (cpu_reset) pc <= '0;
    else if (!(halt_mode && pc == 15'd3)) pc <= pc + 15'd1;
    if (cpu_reset_2) pc_2 <= '0;
    else if (pc_2 != 15'd4) pc_2 <= pc_2 + 15'd1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];       // {res_last, res_data} for instance 1
  logic [16:0] exp2_q[$];      // {res_last, res_data} for instance 2
  logic [14:0] exp_addr_q[$];  // READ addresses for instance 2

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int         run_cnt  = 0;
  int         hold_cnt = 0;
  seq_state_t prev_state = ST_IDLE;

  // Monitor: outputs sampled on the falling edge, so a beat seen here with
  // valid && ready transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", {res_last, res_data}, 17'h0);
        else check("res_word", {res_last, res_data}, exp_q.pop_front());
      end
      if (!host_sel) check("we_while_cpu", ram_we, 0);
      if (state_dbg == ST_IDLE) hold_cnt = 0;
      else if (state_dbg == ST_HOLD) hold_cnt++;
      if (state_dbg == ST_HOLD) run_cnt = 0;
      else if (!host_sel) run_cnt++;
      if (state_dbg == ST_RUN && prev_state == ST_LOAD) check("hold_cycles", hold_cnt, RESET_CYCLES);
      prev_state = state_dbg;

      if (res_valid_2 && res_ready_2) begin
        if (exp2_q.size() == 0) check("res2_unexpected", {res_last_2, res_data_2}, 17'h0);
        else check("res2_word", {res_last_2, res_data_2}, exp2_q.pop_front());
      end
      if (state_dbg_2 == ST_READ) begin
        if (exp_addr_q.size() == 0) check("read2_unexpected", ram_addr_2, 15'h0);
        else check("read2_addr", ram_addr_2, exp_addr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_arg(input bit second, input logic [15:0] d);
    bit got = 1'b0;
    if (second) begin arg_valid_2 = 1'b1; arg_data_2 = d; end
    else begin arg_valid = 1'b1; arg_data = d; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (second ? arg_ready_2 : arg_ready) begin got = 1'b1; break; end
    end
    if (!got) check("arg_accept", 0, 1);
    @(posedge clk); #1;
    if (second) arg_valid_2 = 1'b0;
    else arg_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit second);
    bit got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!(second ? busy_2 : busy)) begin got = 1'b1; break; end
    end
    if (!got) check("case_done", 0, 1);
  endtask

  localparam logic [38:0] RESET_OUTS = {1'b1, 1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 4'b0000};

  function automatic logic [38:0] outs1();
    return {cpu_reset, host_sel, arg_ready, ram_we, ram_addr, ram_wdata,
            res_valid, res_last, timeout, busy};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        halt;
    logic [15:0] exp_res;
    logic        exp_to;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen_valid;
    logic [15:0] ra, rb;

    vecs[0] = '{16'd2,      16'd3,  1'b1, 16'd5,   1'b0};
    vecs[1] = '{16'd566,    16'd3,  1'b1, 16'd569, 1'b0};
    vecs[2] = '{16'd5,      16'd5,  1'b1, 16'd10,  1'b0};
    vecs[3] = '{16'hFFFF,   16'd2,  1'b1, 16'd1,   1'b0};
    vecs[4] = '{16'd7,      16'd9,  1'b0, 16'd16,  1'b1};
    vecs[5] = '{16'd100,    16'd23, 1'b1, 16'd123, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outs", outs1(), RESET_OUTS);
    check("reset_state", state_dbg, ST_IDLE);
    check("reset_outs2", {res_valid_2, busy_2, timeout_2}, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", outs1(), RESET_OUTS);

    // Table-driven cases, back to back.
    foreach (vecs[i]) begin
      halt_mode = vecs[i].halt;
      exp_q.push_back({1'b1, vecs[i].exp_res});
      push_arg(1'b0, vecs[i].a);
      push_arg(1'b0, vecs[i].b);
      wait_idle(1'b0);
      check("timeout_flag", timeout, vecs[i].exp_to);
      if (vecs[i].exp_to) check("run_len_budget", run_cnt, RUN_CYCLES);
      else check("run_len_halt", (run_cnt > 0) && (run_cnt < RUN_CYCLES), 1);
      check("queue_drained", exp_q.size(), 0);
    end

    // Result backpressure: ready low for 10 cycles with the word on offer.
    halt_mode = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    exp_q.push_back({1'b1, 16'd42});
    push_arg(1'b0, 16'd20);
    push_arg(1'b0, 16'd22);
    seen_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (res_valid) begin seen_valid = 1'b1; break; end
    end
    check("bp_valid_seen", seen_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold", {res_valid, res_last, res_data}, {1'b1, 1'b1, 16'd42});
      check("bp_state", state_dbg, ST_EMIT);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_idle(1'b0);
    check("bp_drained", exp_q.size(), 0);

    // Reset pulse in the middle of a run: no result may follow.
    halt_mode = 1'b0;
    push_arg(1'b0, 16'd1);
    push_arg(1'b0, 16'd1);
    repeat (5) @(negedge clk);
    check("mid_in_run", host_sel, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outs", outs1(), RESET_OUTS);
    check("mid_reset_state", state_dbg, ST_IDLE);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (res_valid) seen_valid = 1'b1;
    end
    check("mid_no_result", seen_valid, 0);
    check("mid_idle", {busy, timeout}, 2'b00);

    // Instance 2: three results from 16, 17, 18, last on the third only.
    for (int r = 0; r < 2; r++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      exp2_q.push_back({1'b0, 16'(ra + rb)});
      exp2_q.push_back({1'b0, 16'(ra - rb)});
      exp2_q.push_back({1'b1, 16'(ra ^ rb)});
      exp_addr_q.push_back(15'd16);
      exp_addr_q.push_back(15'd17);
      exp_addr_q.push_back(15'd18);
      push_arg(1'b1, ra);
      push_arg(1'b1, rb);
      wait_idle(1'b1);
      check("multi_timeout", timeout_2, 0);
      check("multi_drained", exp2_q.size() + exp_addr_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_test_sequencer.md
# hack_test_sequencer

Parametrised run controller that drives a Hack `Computer` through repeated test cases without testbench hand-poking of internal RAM. For each case it holds the CPU in reset, writes `NUM_ARGS` argument words into data RAM, releases the CPU for a bounded run with optional halt detection, then reads back `NUM_RESULTS` result words as a stream. It sits beside `Computer` in the simulation/FPGA top and owns the host side of the RAM port mux.

## Interface
- `DATA_W`, 16: RAM word width.
- `ADDR_W`, 15: RAM address width.
- `NUM_ARGS`, 2: words loaded per case at `ARG_BASE..ARG_BASE+NUM_ARGS-1`.
- `ARG_BASE`, 0: first argument address.
- `NUM_RESULTS`, 1: words read back per case from `RES_BASE..`.
- `RES_BASE`, 2: first result address.
- `RESET_CYCLES`, 4: CPU reset hold per case, ≥1.
- `RUN_CYCLES`, 50: run-cycle budget, ≥1.
- `HALT_DETECT`, 1: 1 enables early stop on a stalled PC.
- `HALT_WINDOW`, 4: consecutive cycles with unchanged PC that count as halted, ≥2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `arg_valid` in 1, `arg_data` in DATA_W, `arg_ready` out 1: argument stream.
- `cpu_reset` out 1: drives `Computer.reset`.
- `host_sel` out 1: 1 routes the RAM port to this block, 0 to the CPU.
- `ram_we` out 1, `ram_addr` out ADDR_W, `ram_wdata` out DATA_W: host RAM port.
- `ram_rdata` in DATA_W: RAM read data.
- `pc` in ADDR_W: CPU program counter.
- `res_valid` out 1, `res_data` out DATA_W, `res_ready` in 1: result stream.
- `res_last` out 1: marks the final result word of a case.
- `timeout` out 1: sticky per case; run budget exhausted without a halt.
- `busy` out 1: not in IDLE.

## Operation
- States: IDLE, HOLD, LOAD, RUN, READ, EMIT.
- IDLE: `cpu_reset`=1, `host_sel`=1. The first beat of `arg_valid` starts a case and goes to HOLD. That beat is not consumed.
- HOLD: `cpu_reset`=1 for `RESET_CYCLES`. Clears `timeout`. Goes to LOAD.
- LOAD: `arg_ready`=1. Each handshake writes `arg_data` to `ARG_BASE+i` with `ram_we`=1 in the same cycle. After `NUM_ARGS` writes, goes to RUN.
- RUN: `cpu_reset`=0, `host_sel`=0, `ram_we`=0. A cycle counter starts at 0.
  - Halt: `HALT_DETECT`=1 and `pc` unchanged for `HALT_WINDOW` consecutive cycles. Goes to READ.
  - Budget: counter reaches `RUN_CYCLES-1`. Goes to READ and sets `timeout`.
  - If the halt condition and the budget limit are met in the same cycle, halt wins and `timeout` stays 0.
- READ: `cpu_reset`=1, `host_sel`=1. Drives `ram_addr`=`RES_BASE+j`. `ram_rdata` is captured one cycle later (1-cycle read latency). Goes to EMIT.
- EMIT: `res_valid`=1, holding the captured word until `res_ready`. `res_last`=1 when j=`NUM_RESULTS-1`. After the handshake, the next step is READ with j+1, or IDLE after the last word.
- Address arithmetic is mod 2^ADDR_W; `ARG_BASE+i` wraps silently.
- The PC-compare register holds the previous `pc` and is reloaded on entry to RUN.

## Timing
- Reset (`rst_n`=0, any state, async): state=IDLE.
  - Outputs: `cpu_reset`=1, `host_sel`=1, `arg_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `res_valid`=0, `res_last`=0, `timeout`=0, `busy`=0.
  - All counters are cleared.
  - A reset mid-case drops the case and emits no partial result.
- Shortest case length: `RESET_CYCLES + NUM_ARGS + run + 2·NUM_RESULTS` cycles with zero backpressure.
- `arg_ready` is 0 outside LOAD. Argument stalls (`arg_valid`=0) are allowed in LOAD without a timeout.
- `res_data` and `res_last` are stable while `res_valid`=1 and `res_ready`=0.
- `host_sel` changes only on a state transition. `ram_we`=0 whenever `host_sel`=0.

## Structure
- The shared package `hack_pkg` holds the state enum `seq_state_t`, `HACK_DATA_W`=16, and `HACK_ADDR_W`=15.
- One sub-module: `halt_detector`, which contains the PC register, the window counter and the `halted` flag, with a clear input.
- The RAM port mux lives in the top, controlled by `host_sel`. It is not part of this block.

## Test plan
- Args 2, 3, with a program that computes the sum and loops: RAM[2]=5, `res_data`=5, `res_last`=1, `timeout`=0, and the run ends before 50 cycles.
- Three back-to-back cases (2,3 / 566,3 / 5,5): results 5, 569, 10 in order, each preceded by ≥`RESET_CYCLES` of `cpu_reset`.
- Program without a terminal loop and `HALT_DETECT`=0: the run lasts exactly `RUN_CYCLES` cycles, then `timeout`=1.
- `res_ready` held low for 10 cycles: `res_valid` and `res_data` stay stable, and the state does not advance.
- `rst_n` pulsed low during RUN: all outputs take their reset values in the same cycle, and no `res_valid` occurs.
- `NUM_RESULTS`=3, `RES_BASE`=16: the reads hit addresses 16, 17, 18, and `res_last` is asserted on the third word only.
